// File: rtl/cdf_accumulator.sv
// Streaming 8-bit intensity histogram with a per-frame cumulative pass.
// Pixels are counted in ACCUM. On the last pixel, PREFIX walks the bins one
// per cycle. It writes the cumulative vector, captures the first non-zero
// value and clears the counts. DONE then pulses the start strobe to the
// LUT calculator.
module cdf_accumulator #(
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned inWidth      = $clog2(640 * 480),
    parameter int unsigned numIntLevels = 2 ** DataWidth
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_pixel_valid,
    input  logic [DataWidth-1:0]              i_pixel,
    input  logic                              i_pixel_last,
    output logic                              o_pixel_ready,
    output logic [inWidth*numIntLevels-1:0]   o_frequency,
    output logic [inWidth-1:0]                o_cdfMin,
    output logic                              o_start_calc
);

    localparam logic [DataWidth-1:0] KMax = DataWidth'(numIntLevels - 1);

    typedef enum logic [1:0] {StAccum, StPrefix, StDone} state_e;

    state_e               state_q, state_d;
    logic [inWidth-1:0]   cnt_q  [numIntLevels];
    logic [inWidth-1:0]   freq_q [numIntLevels];
    logic [DataWidth-1:0] k_q;
    logic [inWidth-1:0]   run_q;
    logic [inWidth-1:0]   cdf_min_q;
    logic                 min_found_q;
    logic                 ready_q, ready_d;

    logic                 accept;
    logic                 frame_end;
    logic [inWidth-1:0]   cnt_sel;
    logic [inWidth-1:0]   cnt_inc;
    logic [inWidth:0]     sum_wide;
    logic [inWidth-1:0]   sum_sat;

    assign accept    = (state_q == StAccum) && i_pixel_valid && ready_q;
    assign frame_end = accept && i_pixel_last;

    // Saturating increment for the addressed bin and saturating prefix sum.
    always_comb begin
        cnt_sel  = cnt_q[i_pixel];
        cnt_inc  = (&cnt_sel) ? cnt_sel : cnt_sel + inWidth'(1);
        sum_wide = {1'b0, run_q} + {1'b0, cnt_q[k_q]};
        sum_sat  = sum_wide[inWidth] ? {inWidth{1'b1}} : sum_wide[inWidth-1:0];
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-ready decode.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        unique case (state_q)
            StAccum: begin
                ready_d = !frame_end;
                if (frame_end) state_d = StPrefix;
            end
            StPrefix: begin
                ready_d = 1'b0;
                if (k_q == KMax) state_d = StDone;
            end
            StDone: begin
                ready_d = 1'b1;
                state_d = StAccum;
            end
            default: begin
                ready_d = 1'b0;
                state_d = StAccum;
            end
        endcase
    end

    // Ready is registered; reset value 0 gives the one-cycle delay after release.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    // Count array: increment on accept, clear each bin as PREFIX consumes it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '{default: '0};
        end else if (accept) begin
            cnt_q[i_pixel] <= cnt_inc;
        end else if (state_q == StPrefix) begin
            cnt_q[k_q] <= '0;
        end
    end

    // Prefix walk bookkeeping: bin index, running sum and min-found flag.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            k_q         <= '0;
            run_q       <= '0;
            min_found_q <= 1'b0;
        end else if (frame_end) begin
            k_q         <= '0;
            run_q       <= '0;
            min_found_q <= 1'b0;
        end else if (state_q == StPrefix) begin
            k_q   <= k_q + DataWidth'(1);
            run_q <= sum_sat;
            if (sum_sat != '0) min_found_q <= 1'b1;
        end
    end

    // Cumulative outputs: rewritten only during PREFIX, held otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            freq_q    <= '{default: '0};
            cdf_min_q <= '0;
        end else if (state_q == StPrefix) begin
            freq_q[k_q] <= sum_sat;
            if (!min_found_q && sum_sat != '0) cdf_min_q <= sum_sat;
        end
    end

    for (genvar g = 0; g < numIntLevels; g++) begin : g_pack
        assign o_frequency[g*inWidth +: inWidth] = freq_q[g];
    end

    assign o_pixel_ready = ready_q;
    assign o_cdfMin      = cdf_min_q;
    assign o_start_calc  = (state_q == StDone);

endmodule

// File: tb/tb_cdf_accumulator.sv
// Self-checking bench for cdf_accumulator: directed frames with random
// bubbles and values, compared against a histogram/prefix-sum model.
module tb_cdf_accumulator;

    localparam int IW = 19;
    localparam int NL = 256;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               valid;
    logic [7:0]         pixel;
    logic               last;
    logic               ready;
    logic [IW*NL-1:0]   frequency;
    logic [IW-1:0]      cdf_min;
    logic               start_calc;

    always #5 clk = ~clk;

    cdf_accumulator dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_pixel_valid (valid),
        .i_pixel       (pixel),
        .i_pixel_last  (last),
        .o_pixel_ready (ready),
        .o_frequency   (frequency),
        .o_cdfMin      (cdf_min),
        .o_start_calc  (start_calc)
    );

    int checks = 0;
    int errors = 0;
    int exp_cdf [NL];
    int exp_min;
    int carry = -1;  // pixel value accepted between frames, owed to the next frame

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: histogram of the frame, then plain running sums.
    task automatic build_model(input int pix[$]);
        int hist [NL];
        int run;
        foreach (hist[k]) hist[k] = 0;
        foreach (pix[i]) hist[pix[i]]++;
        if (carry >= 0) begin
            hist[carry]++;
            carry = -1;
        end
        run     = 0;
        exp_min = 0;
        for (int k = 0; k < NL; k++) begin
            run += hist[k];
            exp_cdf[k] = run;
            if (exp_min == 0 && run != 0) exp_min = run;
        end
    endtask

    task automatic check_bins();
        for (int k = 0; k < NL; k++) begin
            chk($sformatf("bin%0d", k), 32'(frequency[k*IW +: IW]), exp_cdf[k]);
        end
        chk("cdfMin", 32'(cdf_min), exp_min);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_start"}, 32'(start_calc), 0);
        chk({tag, "_freq_zero"}, 32'(frequency === '0), 1);
        chk({tag, "_cdfMin"}, 32'(cdf_min), 0);
    endtask

    // mode 0: ramp, 1: constant val, 2: random in 40..200. Returns after the last-accept edge.
    task automatic send_frame(input int n, input int mode, input int val);
        int pix[$];
        int idx;
        int budget;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       pix.push_back(i % NL);
                1:       pix.push_back(val);
                default: pix.push_back(int'($urandom_range(40, 200)));
            endcase
        end
        build_model(pix);
        idx    = 0;
        budget = 0;
        while (idx < n) begin
            @(negedge clk);
            budget++;
            if (budget > 8 * n + 600) begin
                checks++;
                errors++;
                $error("FAIL frame_budget observed %0d expected %0d", idx, n);
                return;
            end
            if ($urandom_range(0, 4) == 0) begin
                valid = 1'b0;
                pixel = 8'($urandom);
                last  = 1'($urandom);
            end else begin
                valid = 1'b1;
                pixel = 8'(pix[idx]);
                last  = (idx == n - 1);
                if (ready) idx++;
            end
        end
        @(posedge clk);
    endtask

    // Cycles T+1..T+258 after the last accept; optionally hold a pixel of 7.
    task automatic check_done(input bit hold);
        for (int n = 1; n <= 258; n++) begin
            @(negedge clk);
            if (hold) begin
                valid = 1'b1;
                pixel = 8'd7;
                last  = 1'b0;
            end else begin
                valid = 1'b0;
                last  = 1'($urandom);
            end
            chk($sformatf("ready_t%0d", n), 32'(ready), 32'(n == 258));
            chk($sformatf("start_t%0d", n), 32'(start_calc), 32'(n == 257));
            if (n == 257) check_bins();
        end
        if (hold) carry = 7;
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b1;
        pixel   = 8'd9;
        last    = 1'b1;

        // Reset with a pixel presented throughout.
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            check_zero("reset");
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_rise", 32'(ready), 1);
        valid = 1'b0;

        // Ramp frame.
        send_frame(256, 0, 0);
        check_done(1'b0);

        // Constant frame, then backpressure with a held pixel of 7.
        send_frame(300, 1, 100);
        check_done(1'b1);
        send_frame(299, 1, 7);
        check_done(1'b0);

        // Back-to-back frames.
        send_frame(256, 0, 0);
        check_done(1'b0);
        send_frame(400, 1, 5);
        check_done(1'b0);

        // Random-valued frame.
        send_frame(600, 2, 0);
        check_done(1'b0);

        // Reset at T+100 during PREFIX of a ramp frame.
        send_frame(256, 0, 0);
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            valid = 1'b0;
            chk("prefix_start", 32'(start_calc), 0);
            chk("prefix_ready", 32'(ready), 0);
        end
        @(negedge clk);
        reset_n = 1'b0;
        valid   = 1'b1;
        pixel   = 8'd3;
        repeat (4) begin
            @(negedge clk);
            check_zero("midreset");
        end
        reset_n = 1'b1;
        valid   = 1'b0;
        @(negedge clk);
        chk("ready_rise2", 32'(ready), 1);
        chk("no_start_after_reset", 32'(start_calc), 0);
        send_frame(300, 1, 100);
        check_done(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cdf_accumulator.md
# cdf_accumulator

Streaming pixel histogram and cumulative-distribution builder for the histogram-equalization path. It counts 8-bit intensities over one frame. At frame end it converts the per-level counts into a cumulative frequency vector and finds the minimum non-zero CDF value. It then pulses a start strobe to the scaled-histogram (LUT) calculator, which consumes `o_frequency`, `o_cdfMin` and `o_start_calc` directly.

## Interface
- `DataWidth`, 8, pixel intensity width
- `inWidth`, `$clog2(640*480)` (=19), width of each count / cumulative value
- `numIntLevels`, `2**DataWidth` (=256), number of intensity bins
- `i_clk`  in  1  clock
- `i_reset_n`  in  1  reset, synchronous, active-low; clock `i_clk`
- `i_pixel_valid`  in  1  pixel present on `i_pixel`
- `i_pixel`  in  DataWidth  pixel intensity
- `i_pixel_last`  in  1  marks last pixel of the frame; qualified by the valid/ready handshake
- `o_pixel_ready`  out  1  block accepts a pixel this cycle (registered)
- `o_frequency`  out  inWidth*numIntLevels  cumulative count; bin k at `[k*inWidth +: inWidth]`
- `o_cdfMin`  out  inWidth  first non-zero cumulative value of the last completed frame
- `o_start_calc`  out  1  one-cycle pulse: `o_frequency`/`o_cdfMin` valid, start LUT calculation

## Operation
- Internal: count array `cnt[0..numIntLevels-1]` of inWidth bits; index `k`; running sum `run`; flag `minFound`.
- States: ACCUM, PREFIX, DONE. Reset state is ACCUM.
- ACCUM:
  - `o_pixel_ready`=1, except the first cycle after reset release.
  - Accept occurs when `i_pixel_valid && o_pixel_ready`. On accept, `cnt[i_pixel]` increments, saturating at 2^inWidth-1.
  - Accept with `i_pixel_last`=1: next state PREFIX; `o_pixel_ready`<=0; `k`<=0; `run`<=0; `minFound`<=0.
- PREFIX: one bin per cycle.
  - `s` = `run + cnt[k]`, saturating at 2^inWidth-1.
  - Update: `run`<=`s`; `o_frequency[k]`<=`s`; `cnt[k]`<=0 (clears the array for the next frame).
  - If `!minFound && s!=0`: `o_cdfMin`<=`s` and `minFound`<=1.
  - When `k==numIntLevels-1`: next state DONE.
- DONE: `o_start_calc`=1 for exactly this cycle; `o_pixel_ready`<=1; next state ACCUM.
- `o_frequency` and `o_cdfMin` hold their values from DONE until the next frame's PREFIX rewrites them.
- A frame always contains at least one pixel (the last), so `o_cdfMin` is never 0 after a completed frame.
- Pixels presented while `o_pixel_ready`=0 are not counted. Upstream must hold them until ready returns.
- `i_pixel_last` without valid&ready has no effect.
- Reset mid-frame or mid-PREFIX:
  - All counts are discarded; every output returns to its reset value.
  - No `o_start_calc` is issued for the interrupted frame.

## Timing
- Reset values:
  - `o_pixel_ready`=0, `o_start_calc`=0, `o_frequency`=0, `o_cdfMin`=0.
  - All `cnt`=0; `run`=0; `k`=0; state ACCUM.
- `o_pixel_ready` rises one cycle after `i_reset_n` goes high.
- Throughput: one pixel per cycle in ACCUM.
- Frame end, last pixel accepted at cycle T:
  - PREFIX occupies T+1..T+256 (bin k written at the end of cycle T+1+k).
  - DONE / `o_start_calc`=1 at T+257.
  - `o_pixel_ready`=0 over T+1..T+257 and 1 again at T+258.
- The count increment from the pixel accepted at T is visible to PREFIX at T+1; no pixel is lost.
- Downstream reads bins for about 258 cycles after the strobe. Frames must therefore be ≥260 pixels for downstream correctness. This block itself processes any frame length correctly.
- Arithmetic is unsigned with no wrap: counts and `run` saturate at 2^inWidth-1. This is unreachable at 640x480 (307200 < 524288).

## Test plan
- Reset: hold `i_reset_n`=0 for 5 cycles with `i_pixel_valid`=1.
  - Required: all outputs 0 throughout; `o_pixel_ready`=1 one cycle after release; no pixel counted during reset.
- Ramp frame: pixels 0..255 once each, `last` on 255, accepted at T.
  - Required: `o_frequency[k]`=k+1 for all k; `o_cdfMin`=1; `o_start_calc` high only at T+257; ready low T+1..T+257.
- Constant frame: 300 pixels, all value 100.
  - Required: `o_frequency[k]`=0 for k<100 and 300 for k≥100; `o_cdfMin`=300.
- Backpressure: keep `i_pixel_valid`=1 with value 7 through PREFIX/DONE, then accept 299 more pixels of 7 with `last`.
  - Required: the held pixel is counted exactly once, after ready returns; frame 2 gives `o_frequency[k≥7]`=300, `o_cdfMin`=300; bubbles (valid=0) are not counted.
- Back-to-back frames: frame 1 = ramp; frame 2 = 400 pixels of value 5.
  - Required: frame 2 `o_frequency[k]`=0 for k<5 and 400 for k≥5 (no residue from frame 1); `o_cdfMin`=400.
- Reset at T+100 during PREFIX of a ramp frame.
  - Required: no `o_start_calc`; outputs 0; the following constant-100 frame of 300 pixels yields the values listed above.
